div_seq: RTL
============

Name: div_seq

Overview:
- Multi-cycle radix-2 restoring divider and its sequencer.
- Serves the EX-stage DIV/DIVU handshake: EX holds div_start (and with it stallreq) high while div_ready is low, then releases the pipeline when div_ready is seen.
- Results go to the HI/LO write path: quotient to LO, remainder to HI.
- Handles signed operands by magnitude conversion, detects divide-by-zero, and supports pipeline flush and stall.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- div_start  in  1  request a division; level-held by EX until div_ready.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with div_start.
- opr1  in  WIDTH  dividend; sampled with div_start.
- opr2  in  WIDTH  divisor; sampled with div_start.
- flush  in  1  exception/pipeline flush; aborts any operation.
- stall  in  1  downstream stall; EX cannot consume the result this cycle.
- div_ready  out  1  result valid.
- quotient  out  WIDTH  LO result.
- remainder  out  WIDTH  HI result.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: state=IDLE; div_ready=0, quotient=0, remainder=0, busy=0; counter and work registers=0.
- States: IDLE, DIVZERO, BUSY, DONE. All outputs are registered.
- IDLE:
  - flush=1 → stay IDLE.
  - Otherwise, div_start=1 latches operands and sign flags.
  - opr2==0 → DIVZERO; else → BUSY with counter=0.
- Operand latch:
  - Signed mode: dividend and divisor stored as magnitudes (two's-complement negate if bit WIDTH-1 set).
  - Record quotient negative = opr1 sign XOR opr2 sign; remainder negative = opr1 sign.
  - Unsigned mode: store operands raw, both sign flags 0.
- Work register: 2*WIDTH bits, initialised {WIDTH'b0, |dividend|}.
- BUSY, one bit per cycle:
  - Shift work left 1.
  - Trial = upper half − |divisor| in WIDTH+1 bits.
  - Trial non-negative → upper half = trial[WIDTH-1:0] and bit 0 = 1; else bit 0 = 0.
  - Counter increments each cycle; after the step with counter==WIDTH-1 → DONE.
- Entering DONE:
  - quotient = lower half, negated if the quotient-negative flag is set.
  - remainder = upper half, negated if the remainder-negative flag is set.
  - div_ready=1.
- DIVZERO: one cycle, then → DONE with quotient=0, remainder=0. The exception itself is not raised here.
- DONE:
  - div_ready held 1. Results hold stable while in DONE.
  - stall=0 → IDLE next cycle with div_ready=0 (EX advanced).
  - stall=1 → remain DONE, so EX does not re-request a completed division.
- Latency, start in IDLE at edge 0:
  - Nonzero divisor: div_ready high after edge 33.
  - Zero divisor: div_ready high after edge 2.
- flush=1 in any state → IDLE next edge, div_ready=0. quotient/remainder are not cleared and are don't-care. flush has priority over div_start and stall.
- div_start while BUSY/DIVZERO/DONE: ignored; operand changes are not resampled.
- A new request is only accepted from IDLE. Back-to-back divisions therefore have one IDLE cycle between DONE and the next acceptance.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. The magnitude of 0x80000000 is 0x80000000 unsigned; no trap.
- Reset asserted mid-operation: immediate return to reset values, with no dependence on clk.

Test Plan:
- Unsigned: DIVU opr1=100, opr2=7, stall=0 → div_ready rises 33 cycles after acceptance with quotient=14, remainder=2; one cycle later div_ready=0 and busy=0.
- Signed: DIV opr1=0xFFFFFFF9 (−7), opr2=2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Also DIV 7 / −2 → quotient=0xFFFFFFFD, remainder=1.
- Divide-by-zero and overflow:
  - DIVU 0x12345678 / 0 → div_ready after 2 cycles, quotient=0, remainder=0.
  - DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Flush: start DIVU 1000/3, assert flush at BUSY cycle 10 → IDLE next cycle with div_ready never asserted. A new DIVU 9/4 issued after the flush returns quotient=2, remainder=1.
- Stall: hold stall=1 for 5 cycles after div_ready rises for DIVU 0xFFFFFFFF/16 → div_ready stays 1 with quotient=0x0FFFFFFF, remainder=15 stable; IDLE one cycle after stall drops; no recomputation.
- Reset: assert rst asynchronously mid-BUSY, between clock edges → outputs read 0 immediately; after release, DIVU 50/5 yields quotient=10, remainder=0.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Signed operands are divided as magnitudes; the signs are fixed up when the result is loaded.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  input  logic             flush,
  input  logic             stall,
  output logic             div_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d, shifted, work_step;
  logic [WIDTH-1:0] dsor_q, dsor_d, mag1, mag2, q_d, r_d;
  logic [WIDTH:0] trial;
  logic qneg_q, qneg_d, rneg_q, rneg_d, ready_d, busy_d, accept, last;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = div_start ? ((opr2 == '0) ? DIVZERO : BUSY) : IDLE;
      DIVZERO: state_d = DONE;
      BUSY:    state_d = last ? DONE : BUSY;
      DONE:    state_d = stall ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end
  // The bit shifted out of the work register is the trial's carry, so divisors above 2^(WIDTH-1) stay exact.
  always_comb begin
    last      = cnt_q == CNT_W'(WIDTH - 1);
    accept    = state_q == IDLE && !flush && div_start;
    mag1      = (div_signed && opr1[WIDTH-1]) ? -opr1 : opr1;
    mag2      = (div_signed && opr2[WIDTH-1]) ? -opr2 : opr2;
    shifted   = {work_q[2*WIDTH-2:0], 1'b0};
    trial     = {work_q[2*WIDTH-1], shifted[2*WIDTH-1:WIDTH]} - {1'b0, dsor_q};
    work_step = trial[WIDTH] ? shifted : {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    work_d    = accept ? {{WIDTH{1'b0}}, mag1} : (state_q == BUSY) ? work_step : work_q;
    dsor_d    = accept ? mag2 : dsor_q;
    qneg_d    = accept ? (div_signed & (opr1[WIDTH-1] ^ opr2[WIDTH-1])) : qneg_q;
    rneg_d    = accept ? (div_signed & opr1[WIDTH-1]) : rneg_q;
    cnt_d     = accept ? '0 : (state_q == BUSY) ? cnt_q + CNT_W'(1) : cnt_q;
    q_d       = (state_q == DIVZERO) ? '0 :
                (state_q == BUSY && last) ? (qneg_q ? -work_step[WIDTH-1:0] : work_step[WIDTH-1:0]) :
                quotient;
    r_d       = (state_q == DIVZERO) ? '0 :
                (state_q == BUSY && last) ? (rneg_q ? -work_step[2*WIDTH-1:WIDTH] : work_step[2*WIDTH-1:WIDTH]) :
                remainder;
    ready_d   = state_d == DONE;
    busy_d    = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q     <= '0;
      work_q    <= '0;
      dsor_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      dsor_q    <= dsor_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      quotient  <= q_d;
      remainder <= r_d;
      div_ready <= ready_d;
      busy      <= busy_d;
    end
endmodule
